// File: rtl/axi_wr_arbiter.sv
// Two-master AXI3 write-path arbiter: one whole transaction (AW, W beats, B) owns the
// slave port at a time, round-robin between masters, with a sticky burst-length check.

module axi_wr_arbiter_port #(
    parameter int ID_W = 4
) (
    input  logic            sel_i,
    input  logic            aw_en_i,
    input  logic            w_en_i,
    input  logic            b_en_i,
    input  logic            s_awready_i,
    input  logic            s_wready_i,
    input  logic            s_bvalid_i,
    input  logic [ID_W-1:0] s_bid_i,
    input  logic [1:0]      s_bresp_i,
    output logic            m_awready_o,
    output logic            m_wready_o,
    output logic            m_bvalid_o,
    output logic [ID_W-1:0] m_bid_o,
    output logic [1:0]      m_bresp_o
);
    logic b_sel;

    // Everything toward a master is gated by ownership and by the channel's active phase.
    assign b_sel       = sel_i & b_en_i;
    assign m_awready_o = sel_i & aw_en_i & s_awready_i;
    assign m_wready_o  = sel_i & w_en_i & s_wready_i;
    assign m_bvalid_o  = b_sel & s_bvalid_i;
    assign m_bid_o     = b_sel ? s_bid_i : '0;
    assign m_bresp_o   = b_sel ? s_bresp_i : '0;
endmodule

module axi_wr_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [1:0]               M_AWVALID,
    output logic [1:0]               M_AWREADY,
    input  logic [1:0][ID_W-1:0]     M_AWID,
    input  logic [1:0][ADDR_W-1:0]   M_AWADDR,
    input  logic [1:0][3:0]          M_AWLEN,
    input  logic [1:0][2:0]          M_AWSIZE,
    input  logic [1:0][1:0]          M_AWBURST,
    input  logic [1:0]               M_WVALID,
    output logic [1:0]               M_WREADY,
    input  logic [1:0][ID_W-1:0]     M_WID,
    input  logic [1:0][DATA_W-1:0]   M_WDATA,
    input  logic [1:0][DATA_W/8-1:0] M_WSTRB,
    input  logic [1:0]               M_WLAST,
    output logic [1:0]               M_BVALID,
    input  logic [1:0]               M_BREADY,
    output logic [1:0][ID_W-1:0]     M_BID,
    output logic [1:0][1:0]          M_BRESP,
    output logic                     S_AWVALID,
    input  logic                     S_AWREADY,
    output logic [ID_W-1:0]          S_AWID,
    output logic [ADDR_W-1:0]        S_AWADDR,
    output logic [3:0]               S_AWLEN,
    output logic [2:0]               S_AWSIZE,
    output logic [1:0]               S_AWBURST,
    output logic                     S_WVALID,
    input  logic                     S_WREADY,
    output logic [ID_W-1:0]          S_WID,
    output logic [DATA_W-1:0]        S_WDATA,
    output logic [DATA_W/8-1:0]      S_WSTRB,
    output logic                     S_WLAST,
    input  logic                     S_BVALID,
    output logic                     S_BREADY,
    input  logic [ID_W-1:0]          S_BID,
    input  logic [1:0]               S_BRESP,
    output logic [1:0]               GRANT,
    output logic                     LEN_ERR
);
    localparam int NUM_M = 2;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e     state_q, state_d;
    logic       g_q, g_d;
    logic       prio_q, prio_d;
    logic       len_err_q, len_err_d;
    logic [3:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;

    logic       aw_act, w_act, b_act;
    logic       aw_hs, w_hs, b_hs;
    logic [1:0] sel;

    assign aw_act = (state_q == ADDR);
    assign w_act  = (state_q == DATA);
    assign b_act  = (state_q == RESP);
    assign sel    = g_q ? 2'b10 : 2'b01;

    assign aw_hs = aw_act & M_AWVALID[g_q] & S_AWREADY;
    assign w_hs  = w_act & M_WVALID[g_q] & S_WREADY;
    assign b_hs  = b_act & S_BVALID & M_BREADY[g_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            g_q       <= 1'b0;
            prio_q    <= 1'b0;
            len_err_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            prio_q    <= prio_d;
            len_err_q <= len_err_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        prio_d    = prio_q;
        len_err_d = len_err_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (|M_AWVALID) begin
                    g_d     = (&M_AWVALID) ? prio_q : M_AWVALID[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d   = M_AWLEN[g_q];
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                    // Early WLAST or a missing WLAST on the final beat are both flagged;
                    // only WLAST ever ends the data phase so the slave sees a closed burst.
                    if (M_WLAST[g_q]) begin
                        if (cnt_q != len_q) len_err_d = 1'b1;
                        state_d = RESP;
                    end else if (cnt_q == len_q) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    prio_d  = ~g_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign S_AWVALID = aw_act & M_AWVALID[g_q];
    assign S_AWID    = aw_act ? M_AWID[g_q]    : '0;
    assign S_AWADDR  = aw_act ? M_AWADDR[g_q]  : '0;
    assign S_AWLEN   = aw_act ? M_AWLEN[g_q]   : '0;
    assign S_AWSIZE  = aw_act ? M_AWSIZE[g_q]  : '0;
    assign S_AWBURST = aw_act ? M_AWBURST[g_q] : '0;

    assign S_WVALID  = w_act & M_WVALID[g_q];
    assign S_WID     = w_act ? M_WID[g_q]   : '0;
    assign S_WDATA   = w_act ? M_WDATA[g_q] : '0;
    assign S_WSTRB   = w_act ? M_WSTRB[g_q] : '0;
    assign S_WLAST   = w_act & M_WLAST[g_q];

    assign S_BREADY  = b_act & M_BREADY[g_q];

    assign GRANT   = (state_q == IDLE) ? 2'b00 : sel;
    assign LEN_ERR = len_err_q;

    for (genvar i = 0; i < NUM_M; i++) begin : g_port
        axi_wr_arbiter_port #(.ID_W(ID_W)) u_port (
            .sel_i       (sel[i]),
            .aw_en_i     (aw_act),
            .w_en_i      (w_act),
            .b_en_i      (b_act),
            .s_awready_i (S_AWREADY),
            .s_wready_i  (S_WREADY),
            .s_bvalid_i  (S_BVALID),
            .s_bid_i     (S_BID),
            .s_bresp_i   (S_BRESP),
            .m_awready_o (M_AWREADY[i]),
            .m_wready_o  (M_WREADY[i]),
            .m_bvalid_o  (M_BVALID[i]),
            .m_bid_o     (M_BID[i]),
            .m_bresp_o   (M_BRESP[i])
        );
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: master/slave agents around the DUT, a transaction-level
// scoreboard, a directed burst-length table and a few hand-written corner sequences.
module tb_axi_wr_arbiter;
    logic             clk, resetn;
    logic [1:0]       M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_WLAST, M_BVALID, M_BREADY;
    logic [1:0][3:0]  M_AWID, M_AWLEN, M_WID, M_WSTRB, M_BID;
    logic [1:0][31:0] M_AWADDR, M_WDATA;
    logic [1:0][2:0]  M_AWSIZE;
    logic [1:0][1:0]  M_AWBURST, M_BRESP;
    logic             S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST, S_BVALID, S_BREADY;
    logic [3:0]       S_AWID, S_AWLEN, S_WID, S_WSTRB, S_BID;
    logic [31:0]      S_AWADDR, S_WDATA;
    logic [2:0]       S_AWSIZE;
    logic [1:0]       S_AWBURST, S_BRESP, GRANT;
    logic             LEN_ERR;

    axi_wr_arbiter dut (
        .clk(clk), .resetn(resetn),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWID(M_AWID), .M_AWADDR(M_AWADDR),
        .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WID(M_WID), .M_WDATA(M_WDATA),
        .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR),
        .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WID(S_WID), .S_WDATA(S_WDATA),
        .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
        .GRANT(GRANT), .LEN_ERR(LEN_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nb;
        logic [31:0] base;
        logic [3:0]  strb;
    } txn_t;

    typedef struct {
        int         mst;
        logic [3:0] len;
        int         nb;
        bit         exp_err;
        int         exp_beats;
    } tv_t;

    int nvec = 0, nerr = 0, cyc = 0, done_cnt = 0, sl_wbeats = 0;
    txn_t pq[2][$];
    txn_t cur[2];
    bit   act[2], awd[2], awv[2], wv[2], wld[2];
    int   beat[2];
    int   own, prio_m, vpct, rdy, aw_stall, b_stall;
    bit   w_tog, exp_err, b_pend, aw_hold, w_hold;
    logic [1:0]  req_prev, b_resp;
    logic [3:0]  b_id, sl_id;
    logic [44:0] aw_sav;
    logic [40:0] w_sav;
    int   glog[$], gcyc[$];

    task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic bit rnd(int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic logic [127:0] allout();
        return 128'({M_AWREADY, M_WREADY, M_BVALID, M_BID, M_BRESP, S_AWVALID, S_AWID, S_AWADDR,
                     S_AWLEN, S_AWSIZE, S_AWBURST, S_WVALID, S_WID, S_WDATA, S_WSTRB, S_WLAST,
                     S_BREADY, GRANT, LEN_ERR});
    endfunction

    function automatic txn_t mk(logic [3:0] id, logic [31:0] addr, logic [3:0] len, int nb,
                                logic [31:0] base);
        txn_t t;
        t.id = id; t.addr = addr; t.len = len; t.nb = nb; t.base = base;
        t.size = 3'd2; t.burst = 2'b01; t.strb = 4'hF;
        return t;
    endfunction

    task automatic load();
        for (int m = 0; m < 2; m++)
            if (!act[m] && pq[m].size() > 0) begin
                cur[m] = pq[m].pop_front();
                act[m] = 1; awd[m] = 0; awv[m] = 0; wv[m] = 0; wld[m] = 0; beat[m] = 0;
            end
    endtask

    task automatic push(int m, txn_t t);
        pq[m].push_back(t);
        load();
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (act[m]) begin
                if (!awd[m] && !awv[m] && rnd(vpct)) awv[m] = 1;
                if (!wld[m] && !wv[m] && rnd(vpct)) wv[m] = 1;
                M_AWVALID[m] = awv[m];     M_AWID[m] = cur[m].id;   M_AWADDR[m] = cur[m].addr;
                M_AWLEN[m] = cur[m].len;   M_AWSIZE[m] = cur[m].size; M_AWBURST[m] = cur[m].burst;
                M_WVALID[m] = wv[m];       M_WID[m] = cur[m].id;
                M_WDATA[m] = cur[m].base + 32'(beat[m]);
                M_WSTRB[m] = cur[m].strb;  M_WLAST[m] = (beat[m] == cur[m].nb - 1);
            end else begin
                M_AWVALID[m] = 0; M_AWID[m] = 0; M_AWADDR[m] = 0; M_AWLEN[m] = 0;
                M_AWSIZE[m] = 0; M_AWBURST[m] = 0; M_WVALID[m] = 0; M_WID[m] = 0;
                M_WDATA[m] = 0; M_WSTRB[m] = 0; M_WLAST[m] = 0;
            end
        end
        S_BVALID = b_pend;
        S_BID    = b_pend ? b_id : 4'd0;
        S_BRESP  = b_pend ? b_resp : 2'd0;
        #1;
        if (aw_stall > 0 && S_AWVALID) begin S_AWREADY = 0; aw_stall--; end
        else S_AWREADY = rnd(rdy);
        S_WREADY = w_tog ? ~S_WREADY : rnd(rdy);
        for (int m = 0; m < 2; m++)
            if (b_stall > 0 && M_BVALID[m]) begin M_BREADY[m] = 0; b_stall--; end
            else M_BREADY[m] = rnd(rdy);
    endtask

    task automatic observe();
        int o, ex;
        bit oawd, owld, xw;
        if (aw_hold) chk("aw_stable", {S_AWVALID, S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST},
                         {1'b1, aw_sav});
        if (w_hold) chk("w_stable", {S_WVALID, S_WID, S_WDATA, S_WSTRB, S_WLAST}, {1'b1, w_sav});
        if (own < 0) begin
            if (req_prev != 2'b00) begin
                ex = (req_prev == 2'b11) ? prio_m : (req_prev[1] ? 1 : 0);
                chk("grant", GRANT, 2'b01 << ex);
                own = ex; glog.push_back(ex); gcyc.push_back(cyc);
            end else chk("idle_gnt", GRANT, 0);
        end else chk("gnt_hold", GRANT, 2'b01 << own);
        for (int m = 0; m < 2; m++)
            if (m != own) chk("other_m", {M_AWREADY[m], M_WREADY[m], M_BVALID[m], M_BID[m], M_BRESP[m]}, 0);
        if (own < 0) begin
            chk("idle_s", {S_AWVALID, S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_WVALID, S_WID,
                           S_WDATA, S_WSTRB, S_WLAST, S_BREADY}, 0);
        end else begin
            o = own; oawd = awd[o]; owld = wld[o]; xw = oawd && !owld;
            chk("s_awvalid", S_AWVALID, !oawd && M_AWVALID[o]);
            chk("m_awready", M_AWREADY[o], !oawd && S_AWREADY);
            chk("s_aw_pay", {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST},
                oawd ? 45'd0 : {M_AWID[o], M_AWADDR[o], M_AWLEN[o], M_AWSIZE[o], M_AWBURST[o]});
            chk("s_wvalid", S_WVALID, xw && M_WVALID[o]);
            chk("m_wready", M_WREADY[o], xw && S_WREADY);
            chk("s_w_pay", {S_WID, S_WDATA, S_WSTRB, S_WLAST},
                xw ? {M_WID[o], M_WDATA[o], M_WSTRB[o], M_WLAST[o]} : 41'd0);
            chk("s_bready", S_BREADY, owld && M_BREADY[o]);
            chk("m_b", {M_BVALID[o], M_BID[o], M_BRESP[o]}, owld ? {S_BVALID, S_BID, S_BRESP} : 7'd0);
            if (S_WVALID && S_WREADY) begin
                chk("w_beat", {S_WID, S_WDATA, S_WSTRB, S_WLAST},
                    {cur[o].id, cur[o].base + 32'(beat[o]), cur[o].strb, 1'(beat[o] == cur[o].nb - 1)});
                wv[o] = 0; sl_wbeats++;
                if (beat[o] == cur[o].nb - 1) wld[o] = 1;
                beat[o]++;
                if (S_WLAST) begin b_pend = 1; b_id = sl_id; b_resp = 2'($urandom_range(3)); end
            end
            if (S_AWVALID && S_AWREADY) begin
                chk("aw_txn", {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST},
                    {cur[o].id, cur[o].addr, cur[o].len, cur[o].size, cur[o].burst});
                awd[o] = 1; awv[o] = 0; sl_id = S_AWID;
            end
            if (S_BVALID && S_BREADY) begin
                exp_err = exp_err | (cur[o].nb != int'(cur[o].len) + 1);
                chk("len_err", LEN_ERR, exp_err);
                b_pend = 0; act[o] = 0; done_cnt++; prio_m = 1 - o; own = -1;
            end
        end
        aw_hold = S_AWVALID && !S_AWREADY;
        aw_sav  = {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST};
        w_hold  = S_WVALID && !S_WREADY;
        w_sav   = {S_WID, S_WDATA, S_WSTRB, S_WLAST};
        req_prev = (GRANT == 2'b00) ? M_AWVALID : 2'b00;
        load();
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin tick(); n++; end
        chk("done_cnt", done_cnt, target);
    endtask

    task automatic do_reset();
        resetn = 0;
        M_AWVALID = 0; M_AWID = 0; M_AWADDR = 0; M_AWLEN = 0; M_AWSIZE = 0; M_AWBURST = 0;
        M_WVALID = 0; M_WID = 0; M_WDATA = 0; M_WSTRB = 0; M_WLAST = 0; M_BREADY = 0;
        S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_BID = 0; S_BRESP = 0;
        for (int m = 0; m < 2; m++) begin pq[m].delete(); act[m] = 0; end
        own = -1; prio_m = 0; exp_err = 0; b_pend = 0; aw_hold = 0; w_hold = 0; req_prev = 0;
        done_cnt = 0; sl_wbeats = 0; glog.delete(); gcyc.delete();
        vpct = 100; rdy = 100; aw_stall = 0; b_stall = 0; w_tog = 0;
        repeat (2) @(posedge clk);
        #1 chk("rst_state", allout(), 0);
        @(posedge clk);
        #1 resetn = 1;
    endtask

    initial begin
        tv_t tv[6];
        int  n;
        tv[0] = '{0, 4'd3,  4,  1'b0, 4};
        tv[1] = '{0, 4'd1,  1,  1'b1, 1};
        tv[2] = '{0, 4'd0,  3,  1'b1, 3};
        tv[3] = '{1, 4'd0,  1,  1'b0, 1};
        tv[4] = '{1, 4'd15, 16, 1'b0, 16};
        tv[5] = '{1, 4'd2,  2,  1'b1, 2};

        // Directed single transactions, including both burst-length violation shapes.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            push(tv[i].mst, mk(4'(i + 3), 32'h100 + 32'(i * 'h40), tv[i].len, tv[i].nb, 32'hA0));
            run_done(1, 200);
            chk("tv_len_err", LEN_ERR, tv[i].exp_err);
            chk("tv_beats", sl_wbeats, tv[i].exp_beats);
            chk("tv_owner", glog.size() > 0 ? glog[0] : -1, tv[i].mst);
        end

        // Simultaneous requests after reset, two transactions each: strict 0,1,0,1 at full rate.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push(0, mk(4'd1, 32'h1000 + 32'(k * 16), 4'd0, 1, 32'h10 * 32'(k)));
            push(1, mk(4'd2, 32'h2000 + 32'(k * 16), 4'd0, 1, 32'h20 * 32'(k)));
        end
        run_done(4, 100);
        for (int k = 0; k < 4; k++) chk("rr_order", glog.size() > k ? glog[k] : -1, k % 2);
        for (int k = 1; k < 4; k++)
            chk("rr_spacing", gcyc.size() > k ? gcyc[k] - gcyc[k-1] : -1, 4);

        // Backpressure on all three channels, master 1 presenting W before its grant.
        do_reset();
        aw_stall = 3; w_tog = 1; b_stall = 2;
        push(0, mk(4'd5, 32'h300, 4'd3, 4, 32'hB0));
        push(1, mk(4'd6, 32'h400, 4'd1, 2, 32'hC0));
        run_done(2, 200);
        chk("bp_beats", sl_wbeats, 6);
        chk("bp_len_err", LEN_ERR, 0);

        // Reset during the third data beat, then a lone master-1 request.
        do_reset();
        push(0, mk(4'd7, 32'h500, 4'd3, 4, 32'hD0));
        n = 0;
        while (beat[0] < 2 && n < 50) begin tick(); n++; end
        chk("mid_reached", beat[0], 2);
        #2 resetn = 0;
        #1 chk("async_rst", allout(), 0);
        do_reset();
        push(1, mk(4'd8, 32'h600, 4'd1, 2, 32'hE0));
        run_done(1, 100);
        chk("post_rst_owner", glog.size() > 0 ? glog[0] : -1, 1);

        // Random traffic with random readiness, all bursts well-formed.
        do_reset();
        vpct = 70; rdy = 65;
        for (int k = 0; k < 20; k++)
            for (int m = 0; m < 2; m++) begin
                txn_t t;
                t = mk(4'($urandom), $urandom, 4'($urandom_range(7)), 0, $urandom);
                t.nb = int'(t.len) + 1;
                t.size = 3'($urandom_range(2));
                t.burst = 2'($urandom_range(2));
                t.strb = 4'($urandom);
                push(m, t);
            end
        run_done(40, 20000);
        chk("rand_len_err", LEN_ERR, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-master AXI3 write-path arbiter that shares one slave write port (AW, W and B channels) between master 0 and master 1. It grants one complete write transaction at a time, round-robin, from address handshake through write response. It sits between the testbench/master agents and the AXI slave on the `axi` interface. It also flags burst-length/WLAST mismatches.

## Interface
Parameters:
- ID_W, 4, width of AWID/WID/BID
- ADDR_W, 32, address width
- DATA_W, 32, write data width; strobe width is DATA_W/8

Ports (per-master buses are packed, master 0 in the low slice):
- clk  in  1  single clock, all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- M_AWVALID / M_AWREADY  in / out  2  per-master address handshake
- M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST  in  2×(ID_W, ADDR_W, 4, 3, 2)  per-master address fields
- M_WVALID / M_WREADY  in / out  2  per-master data handshake
- M_WID, M_WDATA, M_WSTRB, M_WLAST  in  2×(ID_W, DATA_W, DATA_W/8, 1)  per-master data fields
- M_BVALID / M_BREADY  out / in  2  per-master response handshake
- M_BID, M_BRESP  out  2×(ID_W, 2)  per-master response fields
- S_AWVALID, S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST  out  slave address channel; S_AWREADY in
- S_WVALID, S_WID, S_WDATA, S_WSTRB, S_WLAST  out  slave data channel; S_WREADY in
- S_BVALID, S_BID, S_BRESP  in  slave response channel; S_BREADY out
- GRANT  out  2  one-hot current owner, 0 when idle
- LEN_ERR  out  1  sticky burst-length violation flag

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registers: state, grant index g, priority pointer prio, captured len (4b), beat counter cnt (4b), LEN_ERR.
- IDLE, owner selection:
  - If only one M_AWVALID bit is set, that master wins.
  - If both are set, master `prio` wins.
  - The winner is registered into g, and the FSM moves to ADDR.
- ADDR:
  - S_AW* is driven combinationally from master g.
  - M_AWREADY[g] = S_AWREADY.
  - On S_AWVALID&&S_AWREADY: len ← AWLEN[g], cnt ← 0, go to DATA.
- DATA:
  - S_W* is driven from master g.
  - M_WREADY[g] = S_WREADY.
  - Each W handshake increments cnt.
  - A handshake with WLAST goes to RESP.
  - If WLAST arrives with cnt≠len, set LEN_ERR and still go to RESP.
  - If the beat with cnt==len lacks WLAST, set LEN_ERR and stay in DATA until a WLAST handshake. cnt saturates at 15.
- RESP:
  - M_BVALID[g] = S_BVALID, M_BID[g]/M_BRESP[g] = S_BID/S_BRESP.
  - S_BREADY = M_BREADY[g].
  - On the B handshake: prio ← ~g, go to IDLE.
- Non-granted master, and any channel outside its active state:
  - READY/VALID outputs are 0.
  - Slave-side payload outputs are 0.
  - M_BID/M_BRESP are 0.
- W data is never forwarded before the AW handshake. Masters presenting W early are held off (WREADY=0).
- GRANT = one-hot(g) in ADDR/DATA/RESP, 0 in IDLE.
- LEN_ERR is cleared only by reset.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE, prio=0, GRANT=0, LEN_ERR=0
  - all S_*VALID, S_BREADY, M_*READY, M_BVALID = 0
  - all payload outputs 0
- Reset mid-transaction aborts immediately to the reset state. Masters must reissue.
- Arbitration latency: M_AWVALID sampled high at edge N gives GRANT and S_AWVALID high after edge N, in cycle N+1. There is no combinational path from M_AWVALID to S_AWVALID.
- Data path: within ADDR/DATA/RESP, VALID/READY/payload pass through combinationally, with zero added latency.
- Minimum single-beat transaction with slave ready every cycle:
  - AW handshake at N+1, W at N+2, B at N+3.
  - IDLE in N+4, next grant visible in N+5.
  - Throughput: one transaction per 4 cycles.
- Valid/payload stability toward the slave is inherited from the granted master. The arbiter never retracts S_*VALID before its handshake.
- Simultaneous requests on the first cycle after reset: master 0 wins.

## Test plan
- Single master 0:
  - Stimulus: AWADDR=0x100, AWLEN=3, four WDATA beats 0xA0..0xA3 with WLAST on the 4th.
  - Required: slave sees identical AW/W, BRESP=0 is routed to M_BVALID[0] only, GRANT=01 until B, LEN_ERR=0.
- Both masters assert AWVALID in the same cycle after reset:
  - Required: master 0 is served first. Master 1 is granted in the cycle after master 0's IDLE cycle. M_AWREADY[1] stays 0 throughout master 0's transaction.
- Back-to-back contention over 4 transactions:
  - Required: grant order 0,1,0,1 (round-robin alternation).
- Length violations:
  - AWLEN=1 with WLAST on beat 0 → LEN_ERR=1, FSM goes to RESP.
  - Separately, AWLEN=0 with WLAST on beat 2 → LEN_ERR=1, three beats forwarded.
- Backpressure:
  - Stimulus: S_AWREADY low 3 cycles, S_WREADY toggling, M_BREADY low 2 cycles.
  - Required: no handshake is lost or duplicated, slave-side fields stay stable while stalled, and master 1's early WVALID sees WREADY=0.
- Reset mid-transaction:
  - Stimulus: resetn low during DATA beat 2.
  - Required: all outputs 0 asynchronously. After release, a new master 1 request is granted normally with prio=0 semantics.
